// File: rtl/gumnut_ctrl_fsm.sv
// gumnut_ctrl_fsm: multicycle fetch/decode/execute/memory/write-back sequencer with interrupt entry
module gumnut_ctrl_fsm #(
  parameter bit IE_RST = 1'b0,
  parameter bit ILLEGAL_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [6:0] op_i,
  input  logic [2:0] func_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       int_req_i,
  input  logic       inst_ack_i,
  input  logic       data_ack_i,
  output logic       inst_cyc_o,
  output logic       inst_stb_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [2:0] pc_sel_o,
  output logic       push_o,
  output logic       pop_o,
  output logic       reg_we_o,
  output logic       cc_we_o,
  output logic       data_cyc_o,
  output logic       data_stb_o,
  output logic       data_we_o,
  output logic       port_o,
  output logic       int_ack_o,
  output logic       ie_o,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, INT, WAIT, HALT} state_t;
  state_t st;
  logic ie, inst_cyc, data_cyc, data_we, port;
  logic pc_we_r, push_r, pop_r, reg_we_r, cc_we_r, int_ack_r;
  logic [2:0] pc_sel;
  logic is_alu, is_mem, is_jmp, is_br, is_misc, is_wait, is_ret, br_take, illegal, halt;
  logic exec_misc, ie_nxt, go_int, do_end, fetch_ack;
  assign is_alu = !op_i[6] | op_i[6:4] == 3'b110 | op_i[6:3] == 4'b1110;
  assign is_mem = op_i[6:5] == 2'b10;
  assign is_jmp = op_i[6:2] == 5'b11110;
  assign is_br = op_i[6:1] == 6'b111110;
  assign is_misc = op_i == 7'b1111110;
  assign is_wait = is_misc & func_i[2:1] == 2'b10;
  assign is_ret = is_misc & func_i[2:1] == 2'b00;
  assign br_take = func_i[1] ? c_i ^ func_i[0] : z_i ^ func_i[0];
  assign illegal = op_i == 7'h7f | (is_misc & func_i > 3'd5);
  assign halt = illegal & !ILLEGAL_NOP;
  // enai/reti/disi change ie in time for the same instruction's end-of-instruction interrupt check
  assign exec_misc = st == EXECUTE & is_misc;
  assign ie_nxt = (exec_misc & (func_i == 3'd1 | func_i == 3'd2)) | (ie & !(exec_misc & func_i == 3'd3));
  assign go_int = ie_nxt & int_req_i;
  assign do_end = (st == EXECUTE & !is_alu & !is_mem & !is_wait & !halt) | (st == MEM & data_ack_i & data_we)
                | st == WRITEBACK | (st == WAIT & go_int);
  assign fetch_ack = st == FETCH & inst_cyc & inst_ack_i;
  assign inst_cyc_o = inst_cyc;
  assign inst_stb_o = inst_cyc;
  assign data_cyc_o = data_cyc;
  assign data_stb_o = data_cyc;
  assign data_we_o = data_we;
  assign port_o = port;
  assign ir_we_o = cen & fetch_ack;
  assign pc_we_o = cen & (pc_we_r | fetch_ack);
  assign pc_sel_o = pc_sel;
  assign push_o = cen & push_r;
  assign pop_o = cen & pop_r;
  assign reg_we_o = cen & reg_we_r;
  assign cc_we_o = cen & cc_we_r;
  assign int_ack_o = cen & int_ack_r;
  assign ie_o = ie;
  assign state_o = st;
  // state sequencing; pulse registers describe the cycle being entered and default low
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= FETCH;
      ie <= IE_RST;
      {inst_cyc, data_cyc, data_we, port, pc_we_r, push_r, pop_r, reg_we_r, cc_we_r, int_ack_r} <= '0;
      pc_sel <= 3'd0;
    end else if (cen) begin
      {pc_we_r, push_r, pop_r, reg_we_r, cc_we_r, int_ack_r} <= '0;
      pc_sel <= 3'd0;
      case (st)
        FETCH: begin
          inst_cyc <= !fetch_ack;
          if (fetch_ack) st <= DECODE;
        end
        DECODE: begin
          st <= EXECUTE;
          cc_we_r <= is_alu;
          pc_we_r <= is_jmp | (is_br & br_take) | is_ret;
          pc_sel <= is_jmp ? 3'd1 : (is_br & br_take) ? 3'd2 : is_ret ? 3'd3 : 3'd0;
          push_r <= is_jmp & func_i[0];
          pop_r <= is_ret;
        end
        EXECUTE: begin
          if (halt) begin
            st <= HALT;
            ie <= 1'b0;
          end else if (is_alu) begin
            st <= WRITEBACK;
            reg_we_r <= 1'b1;
          end else if (is_mem) begin
            st <= MEM;
            data_cyc <= 1'b1;
            data_we <= func_i[0];
            port <= func_i[1];
          end else if (is_wait) st <= WAIT;
        end
        MEM: begin
          if (data_ack_i) begin
            {data_cyc, data_we, port} <= '0;
            if (!data_we) begin
              st <= WRITEBACK;
              reg_we_r <= 1'b1;
            end
          end
        end
        INT: begin
          st <= FETCH;
          inst_cyc <= 1'b1;
        end
        WRITEBACK, WAIT, HALT: ;
      endcase
      if (do_end) begin
        st <= go_int ? INT : FETCH;
        ie <= ie_nxt & !go_int;
        inst_cyc <= !go_int;
        push_r <= go_int;
        pc_we_r <= go_int;
        pc_sel <= go_int ? 3'd4 : 3'd0;
        int_ack_r <= go_int;
      end
    end
  end
endmodule

// File: doc/gumnut_ctrl_fsm.md
Name: gumnut_ctrl_fsm

Overview:
- Multicycle control sequencer for the Gumnut core; sits beside the instruction register, PC, register file, ALU and bus interfaces.
- Fetches each 18-bit instruction and loads the instruction register. Decodes the registered op/func fields and sequences execute, memory/port and write-back.
- Handles branch condition evaluation, the interrupt-enable flag and interrupt entry.

Parameters:
IE_RST, 0, reset value of the internal interrupt-enable flag
ILLEGAL_NOP, 1, 1: op=7'h7F or undefined misc func executes as NOP; 0: FSM parks in HALT until reset

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
cen  in  1  clock enable; 0 freezes the FSM
op_i  in  7  registered instruction bits [17:11]
func_i  in  3  func field as decoded from op class
z_i  in  1  zero flag
c_i  in  1  carry flag
int_req_i  in  1  level interrupt request
inst_ack_i  in  1  instruction memory acknowledge
data_ack_i  in  1  data memory / port acknowledge
inst_cyc_o  out  1  instruction bus cycle
inst_stb_o  out  1  instruction bus strobe
ir_we_o  out  1  instruction register load
pc_we_o  out  1  PC write
pc_sel_o  out  3  PC source: 0 pc+1, 1 jump addr, 2 pc+disp, 3 return stack, 4 int vector
push_o  out  1  push PC to return stack (jsb, interrupt)
pop_o  out  1  pop return stack (ret, reti)
reg_we_o  out  1  register file write
cc_we_o  out  1  Z/C flag write
data_cyc_o  out  1  data cycle
data_stb_o  out  1  data strobe
data_we_o  out  1  data write
port_o  out  1  1 = I/O port space (inp/out), 0 = memory
int_ack_o  out  1  interrupt accepted
ie_o  out  1  current interrupt-enable flag
state_o  out  3  current state, for debug

Behaviour:
- Reset (rst=0 at a rising clk):
  - state=FETCH, ie=IE_RST.
  - All outputs 0 except ie_o=IE_RST and state_o=FETCH encoding.
  - Reset mid-bus-cycle drops cyc/stb on the next cycle with no handshake completion.
- cen=0: state and ie hold. Pulse outputs (ir_we, pc_we, push, pop, reg_we, cc_we, int_ack) are forced 0. Bus cyc/stb/we hold their values.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, INT=5, WAIT=6, HALT=7.
- Class decode from op_i:
  - op[6]=0: ALU immediate.
  - op[6:5]=10: memory; func[1:0]: 0 ldm, 1 stm, 2 inp, 3 out.
  - op[6:4]=110: shift.
  - op[6:3]=1110: ALU register.
  - op[6:2]=11110: jump; func[0]: 0 jmp, 1 jsb.
  - op[6:1]=111110: branch; func[1:0]: 0 bz, 1 bnz, 2 bc, 3 bnc.
  - op=1111110: misc; func: 0 ret, 1 reti, 2 enai, 3 disi, 4 wait, 5 stby.
- FETCH:
  - inst_cyc=inst_stb=1 until inst_ack.
  - In the ack cycle: ir_we=1, pc_we=1, sel=0; next state DECODE.
  - No timeout.
- DECODE: one cycle (register read); then EXECUTE.
- EXECUTE:
  - ALU/shift: cc_we=1, then WRITEBACK.
  - Memory: MEM.
  - jmp: pc_we, sel=1.
  - jsb: additionally push=1.
  - Branch: pc_we, sel=2 only if the condition holds (bz: z, bnz: !z, bc: c, bnc: !c).
  - ret: pop, pc_we, sel=3.
  - reti: as ret plus ie set.
  - enai sets ie; disi clears ie.
  - wait/stby: go to WAIT.
  - Control and misc instructions go to END.
- MEM:
  - data_cyc=data_stb=1.
  - data_we=1 for stm/out; port_o=1 for inp/out.
  - Held until data_ack.
  - On ack: ldm/inp go to WRITEBACK; stm/out go to END.
- WRITEBACK: reg_we=1 for one cycle; then END.
- END (transition rule, not a state): if ie & int_req then INT, else FETCH.
- WAIT: idle until int_req & ie, then INT. With ie=0 it waits forever (reset exits).
- INT:
  - One cycle: push=1, pc_we=1, sel=4, int_ack=1, ie cleared.
  - Next state FETCH.
- enai/disi take effect for the END decision of the same instruction: enai followed by a pending request gives INT immediately.
- Illegal op: if ILLEGAL_NOP=1, EXECUTE goes to END with no side effects; else HALT, where all outputs are 0 except state_o.
- Bus acks outside FETCH/MEM are ignored.
- int_req is never sampled mid-instruction.

Test Plan:
- Reset then ALU immediate (op=7'h00, inst_ack on 2nd FETCH cycle) -> ir_we and pc_we pulse in the same cycle; cc_we in EXECUTE; reg_we in WRITEBACK; back to FETCH after 5 cycles.
- ldm (op[6:5]=10, func=0) with data_ack delayed 3 cycles -> data_cyc/stb held 4 cycles, data_we=0, port_o=0, then reg_we=1 once.
- Each branch form with z/c = 0 and 1 -> pc_we, sel=2 only for bz&z=1, bnz&z=0, bc&c=1, bnc&c=0; never otherwise.
- IE_RST=0, int_req=1: disi then enai -> no INT after disi; INT immediately after enai with int_ack=1, push=1, sel=4; ie_o=0 afterwards; reti restores ie_o=1 and pops.
- wait with ie=1, int_req raised 10 cycles later -> state stays WAIT until then, then INT. cen=0 for 3 cycles during MEM -> state held and no pulse outputs.
- Drive rst=0 during MEM with data_stb=1 -> next cycle data_cyc/stb=0, state FETCH, ie_o=IE_RST.
